// File: rtl/systolic_tile_ctrl.sv
// Sequencer for an N x N systolic MAC tile: operand load, skewed wavefront, row drain.
// Optional SYSTOLIC_TILE_CTRL_BACK2BACK_EN queues a start during COMPUTE/DRAIN to chain tiles.
module systolic_tile_ctrl #(
    parameter int N     = 4,
    parameter int K_MAX = 16,
    parameter int KW    = $clog2(K_MAX+1),
    parameter int CW    = $clog2(K_MAX+2*N)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [KW-1:0]     k_len_i,
    input  logic              ready_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [2*N*N-1:0]  mux_o,
    output logic [N*N-1:0]    add_zero_o,
    output logic [N-1:0]      acc_valid_o
);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_COMP, S_DRAIN, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] klen_q, klen_d;
    logic [CW-1:0] k_clamped;
    logic          start_ok;
    logic          take_b2b;
    logic [CW-1:0] next_klen;

    assign k_clamped = (k_len_i > KW'(K_MAX)) ? CW'(K_MAX) : CW'(k_len_i);
    assign start_ok  = start_i && (k_len_i != '0);

`ifdef SYSTOLIC_TILE_CTRL_BACK2BACK_EN
    logic          pend_q, pend_d;
    logic [CW-1:0] shadow_q, shadow_d;
    logic          req_b2b;

    // A request arriving in the final handshake cycle itself still chains.
    assign req_b2b   = start_ok && (state_q == S_COMP || state_q == S_DRAIN);
    assign take_b2b  = pend_q || req_b2b;
    assign next_klen = req_b2b ? k_clamped : shadow_q;

    always_comb begin
        pend_d   = pend_q;
        shadow_d = shadow_q;
        if (req_b2b) begin
            pend_d   = 1'b1;
            shadow_d = k_clamped;
        end
        if (state_q == S_DRAIN && ready_i && cnt_q == CW'(N-1)) pend_d = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pend_q   <= 1'b0;
            shadow_q <= '0;
        end else begin
            pend_q   <= pend_d;
            shadow_q <= shadow_d;
        end
    end
`else
    assign take_b2b  = 1'b0;
    assign next_klen = klen_q;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        klen_d  = klen_q;
        done_o  = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start_ok) begin
                    state_d = S_LOAD;
                    klen_d  = k_clamped;
                end
            end
            S_LOAD: if (cnt_q == CW'(N-1)) begin
                state_d = S_COMP;
                cnt_d   = '0;
            end
            S_COMP: if (cnt_q == klen_q + CW'(2*N-3)) begin
                state_d = S_DRAIN;
                cnt_d   = '0;
            end
            S_DRAIN: begin
                // counter doubles as the drain row index
                cnt_d = cnt_q;
                if (ready_i) begin
                    if (cnt_q == CW'(N-1)) begin
                        cnt_d = '0;
                        if (take_b2b) begin
                            state_d = S_LOAD;
                            klen_d  = next_klen;
                            done_o  = 1'b1;
                        end else begin
                            state_d = S_DONE;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                done_o  = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            klen_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            klen_q  <= klen_d;
        end
    end

    assign busy_o = (state_q != S_IDLE);

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            logic [CW-1:0] off;
            logic          in_wave;
            // Wraps high when the wavefront has not reached this PE; stays above any klen.
            assign off     = cnt_q - CW'(i+j);
            assign in_wave = (state_q == S_COMP) && (off < klen_q);
            assign mux_o[(i*N+j)*2 +: 2] = (state_q == S_LOAD) ? 2'd1 :
                                           in_wave             ? 2'd2 : 2'd0;
            assign add_zero_o[i*N+j] = (state_q == S_COMP) && (off == '0);
        end
        assign acc_valid_o[i] = (state_q == S_DRAIN) && (cnt_q == CW'(i));
    end

endmodule

// File: tb/tb_systolic_tile_ctrl.sv
// Bench for systolic_tile_ctrl: timeline model checked every cycle plus literal spot checks.
module tb_systolic_tile_ctrl;
    localparam int N     = 4;
    localparam int K_MAX = 16;
    localparam int KW    = $clog2(K_MAX+1);

    logic              clk = 1'b0;
    logic              rst_ni;
    logic              start_i;
    logic [KW-1:0]     k_len_i;
    logic              ready_i;
    logic              busy_o, done_o;
    logic [2*N*N-1:0]  mux_o;
    logic [N*N-1:0]    add_zero_o;
    logic [N-1:0]      acc_valid_o;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    systolic_tile_ctrl #(.N(N), .K_MAX(K_MAX)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .k_len_i(k_len_i),
        .ready_i(ready_i), .busy_o(busy_o), .done_o(done_o), .mux_o(mux_o),
        .add_zero_o(add_zero_o), .acc_valid_o(acc_valid_o)
    );

    always #5 clk = ~clk;

    // Model: m_t counts cycles since the accepted start (1 = first LOAD cycle).
    bit m_busy = 0, m_fin = 0, m_pend = 0;
    int m_t = 0, m_klen = 0, m_row = 0, m_shadow = 0;

    function automatic int clampk(int k);
        return (k > K_MAX) ? K_MAX : k;
    endfunction
    function automatic bit st_ok();
        return start_i && (k_len_i != 0);
    endfunction
    function automatic bit in_cd();
        return m_busy && !m_fin && (m_t > N);
    endfunction
    function automatic bit in_drain();
        return m_busy && !m_fin && (m_t > N + m_klen + 2*N - 2);
    endfunction
    function automatic bit b2b_go();
`ifdef SYSTOLIC_TILE_CTRL_BACK2BACK_EN
        return in_drain() && ready_i && (m_row == N-1) && (m_pend || (in_cd() && st_ok()));
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk) begin
        if (!rst_ni) begin
            m_busy <= 0; m_fin <= 0; m_pend <= 0; m_t <= 0; m_klen <= 0; m_row <= 0;
        end else if (!m_busy) begin
            if (st_ok()) begin
                m_busy <= 1; m_fin <= 0; m_t <= 1; m_row <= 0; m_klen <= clampk(int'(k_len_i));
            end
        end else if (m_fin) begin
            m_busy <= 0; m_fin <= 0;
        end else begin
            m_t <= m_t + 1;
`ifdef SYSTOLIC_TILE_CTRL_BACK2BACK_EN
            if (in_cd() && st_ok()) begin
                m_pend <= 1; m_shadow <= clampk(int'(k_len_i));
            end
`endif
            if (in_drain() && ready_i) begin
                if (m_row != N-1) m_row <= m_row + 1;
                else if (b2b_go()) begin
                    m_t <= 1; m_row <= 0; m_pend <= 0;
                    m_klen <= (in_cd() && st_ok()) ? clampk(int'(k_len_i)) : m_shadow;
                end else m_fin <= 1;
            end
        end
    end

    logic [2*N*N-1:0] e_mux;
    logic [N*N-1:0]   e_az;
    logic [N-1:0]     e_acc;
    logic             e_busy, e_done;
    int               c;

    always @(negedge clk) begin
        if (chk_en) begin
            e_mux = '0; e_az = '0; e_acc = '0;
            e_busy = m_busy;
            e_done = m_fin || b2b_go();
            if (m_busy && !m_fin) begin
                if (m_t <= N) begin
                    for (int p = 0; p < N*N; p++) e_mux[p*2 +: 2] = 2'd1;
                end else if (!in_drain()) begin
                    c = m_t - N - 1;
                    for (int i = 0; i < N; i++)
                        for (int j = 0; j < N; j++) begin
                            if (c >= i+j && c < i+j+m_klen) e_mux[(i*N+j)*2 +: 2] = 2'd2;
                            if (c == i+j) e_az[i*N+j] = 1'b1;
                        end
                end else begin
                    e_acc[m_row] = 1'b1;
                end
            end
            checks += 5;
            if (busy_o !== e_busy) begin errors++; $display("FAIL busy t=%0t got %b exp %b", $time, busy_o, e_busy); end
            if (done_o !== e_done) begin errors++; $display("FAIL done t=%0t got %b exp %b", $time, done_o, e_done); end
            if (mux_o !== e_mux) begin errors++; $display("FAIL mux t=%0t got %h exp %h", $time, mux_o, e_mux); end
            if (add_zero_o !== e_az) begin errors++; $display("FAIL add_zero t=%0t got %h exp %h", $time, add_zero_o, e_az); end
            if (acc_valid_o !== e_acc) begin errors++; $display("FAIL acc_valid t=%0t got %b exp %b", $time, acc_valid_o, e_acc); end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic lit(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL lit_%s t=%0t got %0h exp %0h", nm, $time, act, exp);
        end
    endtask

    task automatic start_tile(input int k);
        start_i = 1'b1; k_len_i = KW'(k);
        step();
        start_i = 1'b0; k_len_i = '0;
    endtask

    initial begin
        rst_ni = 1'b0; start_i = 1'b0; k_len_i = '0; ready_i = 1'b1;
        step(); chk_en = 1'b1;
        step(); step();
        rst_ni = 1'b1;
        lit("rst_busy", 64'(busy_o), 0);
        step();

        // Basic tile, k=3, ready always high
        start_tile(3);
        for (int n = 1; n <= 19; n++) begin
            case (n)
                1:  lit("a_load", 64'(mux_o), 64'h5555_5555);
                5:  begin lit("a_mux00_5", 64'(mux_o[1:0]), 2); lit("a_az00", 64'(add_zero_o[0]), 1); end
                7:  lit("a_mux00_7", 64'(mux_o[1:0]), 2);
                8:  lit("a_mux00_8", 64'(mux_o[1:0]), 0);
                11: begin lit("a_az33", 64'(add_zero_o[15]), 1); lit("a_mux33_11", 64'(mux_o[31:30]), 2); end
                13: lit("a_mux33_13", 64'(mux_o[31:30]), 2);
                14: begin lit("a_acc14", 64'(acc_valid_o), 1); lit("a_mux14", 64'(mux_o), 0); end
                17: begin lit("a_acc17", 64'(acc_valid_o), 8); lit("a_done17", 64'(done_o), 0); end
                18: lit("a_done18", 64'(done_o), 1);
                19: lit("a_busy19", 64'(busy_o), 0);
                default: ;
            endcase
            step();
        end

        // Drain backpressure at row 1 for 5 cycles
        start_tile(3);
        for (int n = 1; n <= 24; n++) begin
            ready_i = (n >= 15 && n <= 19) ? 1'b0 : 1'b1;
            case (n)
                15: lit("b_acc15", 64'(acc_valid_o), 2);
                19: lit("b_acc19", 64'(acc_valid_o), 2);
                20: lit("b_acc20", 64'(acc_valid_o), 2);
                21: lit("b_acc21", 64'(acc_valid_o), 4);
                22: begin lit("b_acc22", 64'(acc_valid_o), 8); lit("b_done22", 64'(done_o), 0); end
                23: lit("b_done23", 64'(done_o), 1);
                24: lit("b_busy24", 64'(busy_o), 0);
                default: ;
            endcase
            step();
        end
        ready_i = 1'b1;

        // Zero length is ignored
        start_tile(0);
        lit("z_busy", 64'(busy_o), 0);
        step();

        // Clamp 31 -> 16, plus a start during LOAD that must be ignored
        start_tile(31);
        for (int n = 1; n <= 32; n++) begin
            if (n == 2) begin start_i = 1'b1; k_len_i = KW'(5); end
            if (n == 3) begin start_i = 1'b0; k_len_i = '0; end
            case (n)
                5:  lit("c_az00", 64'(add_zero_o[0]), 1);
                26: begin lit("c_acc26", 64'(acc_valid_o), 0); lit("c_mux33_26", 64'(mux_o[31:30]), 2); end
                27: lit("c_acc27", 64'(acc_valid_o), 1);
                31: lit("c_done31", 64'(done_o), 1);
                32: lit("c_busy32", 64'(busy_o), 0);
                default: ;
            endcase
            step();
        end

        // Reset mid-COMPUTE for 3 cycles
        start_tile(4);
        for (int n = 1; n <= 6; n++) step();
        rst_ni = 1'b0;
        step();
        lit("r_busy", 64'(busy_o), 0);
        lit("r_mux", 64'(mux_o), 0);
        step(); step();
        rst_ni = 1'b1;
        for (int n = 0; n < 4; n++) step();

        // Start during DRAIN: chains with the feature, ignored without
        start_tile(3);
        for (int n = 1; n <= 32; n++) begin
            if (n == 15) begin start_i = 1'b1; k_len_i = KW'(2); end
            if (n == 16) begin start_i = 1'b0; k_len_i = '0; end
`ifdef SYSTOLIC_TILE_CTRL_BACK2BACK_EN
            case (n)
                17: lit("d_done17", 64'(done_o), 1);
                18: begin lit("d_load18", 64'(mux_o), 64'h5555_5555); lit("d_done18", 64'(done_o), 0); end
                22: lit("d_az00", 64'(add_zero_o[0]), 1);
                29: begin lit("d_mux33_29", 64'(mux_o[31:30]), 2); lit("d_acc29", 64'(acc_valid_o), 0); end
                30: lit("d_acc30", 64'(acc_valid_o), 1);
                default: ;
            endcase
`else
            case (n)
                17: lit("d_done17", 64'(done_o), 0);
                18: lit("d_done18", 64'(done_o), 1);
                19: lit("d_busy19", 64'(busy_o), 0);
                default: ;
            endcase
`endif
            step();
        end
        for (int n = 0; n < 8; n++) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/systolic_tile_ctrl.md
Name: systolic_tile_ctrl

Overview:
Parametrised controller for an N x N systolic multiply-accumulate array. It sequences one output tile per start: operand load, skewed MAC wavefront of programmable inner length, per-PE accumulator clearing, and a row-by-row result drain under a ready handshake. It replaces the fixed 4x4 single-shot controller. It sits between the tile scheduler (start/length) and the PE grid plus the result writer (ready).

Parameters:
N, 4, array dimension (rows = columns = N), N >= 2
K_MAX, 16, maximum inner (reduction) length per tile
KW, $clog2(K_MAX+1), width of k_len_i
CW, $clog2(K_MAX+2*N), internal phase counter width

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_ni  in  1  synchronous active-low reset
start_i  in  1  begin a tile; sampled only in IDLE (see optional feature)
k_len_i  in  KW  inner length for the tile; latched on accepted start
ready_i  in  1  result writer accepts the current drain row
busy_o  out  1  high in every state except IDLE
done_o  out  1  single-cycle pulse on tile completion
mux_o  out  2*N*N  per-PE select; PE(i,j) at bits [(i*N+j)*2 +: 2]; 0=HOLD, 1=SHIFT_IN, 2=MAC, 3 unused
add_zero_o  out  N*N  per-PE accumulator clear; PE(i,j) at bit i*N+j
acc_valid_o  out  N  one-hot drain row select; bit r = row r result presented

Behaviour:
- Reset (rst_ni=0 at a clock edge): state IDLE, counter 0, latched length 0, pending flag 0; all outputs 0 from the following cycle. Reset mid-tile aborts without done_o.
- Outputs are Moore functions of the registered state and counter; no extra latency.
- States: IDLE, LOAD, COMPUTE, DRAIN, DONE. Counter clears on every state change.
- IDLE: outputs 0. start_i=1 with k_len_i != 0 -> LOAD; latch klen = min(k_len_i, K_MAX). start_i with k_len_i = 0 is ignored.
- LOAD: N cycles (counter 0..N-1); every mux_o field = 1; then -> COMPUTE.
- COMPUTE: klen + 2N - 2 cycles (counter c = 0..klen+2N-3). mux_o(i,j) = 2 when i+j <= c < i+j+klen, else 0. add_zero_o(i,j) = 1 only at c == i+j (first wavefront cycle of that PE). Then -> DRAIN.
- DRAIN: row index r starts at 0; acc_valid_o = 1<<r; all mux_o = 0. Row advances only on a cycle with ready_i=1. Handshake completes at r=N-1 with ready_i=1 -> DONE. ready_i low holds acc_valid_o stable indefinitely.
- DONE: one cycle; done_o=1, busy_o=1, other outputs 0; -> IDLE.
- Without the optional feature, start_i in any non-IDLE state is ignored.
- Length arithmetic in CW bits; k_len_i > K_MAX clamps to K_MAX (no wrap).

Optional Feature:
SYSTOLIC_TILE_CTRL_BACK2BACK_EN
- Defined: start_i with k_len_i != 0 in COMPUTE or DRAIN sets a pending flag and latches the next length into a shadow register (last request wins).
- With pending set, the final DRAIN handshake goes directly to LOAD (skipping DONE/IDLE). done_o pulses in that same handshake cycle, and the shadow length becomes klen.
- The pending flag clears on that transition and on reset.
- Not defined: no shadow register or pending flag; behaviour as in Behaviour.

Test Plan:
- Reset: hold rst_ni=0 for 3 cycles mid-COMPUTE -> all outputs 0 and busy_o=0 the cycle after the first reset edge; no done_o.
- N=4, k_len_i=3, start at edge 0, ready_i=1 -> LOAD cycles 1-4 (mux all 1); COMPUTE cycles 5-13; acc_valid_o 0001,0010,0100,1000 on cycles 14-17; done_o=1 only at cycle 18; busy_o=0 at 19.
- Same run -> PE(0,0) add_zero at cycle 5, mux=2 on cycles 5-7; PE(3,3) add_zero at cycle 11, mux=2 on cycles 11-13.
- Drain backpressure: ready_i=0 for 5 cycles at r=1 -> acc_valid_o holds 0010 for those 5 cycles; total drain = 9 cycles; done_o is delayed by the same amount.
- Boundaries: k_len_i=0 -> start ignored, stays IDLE. k_len_i=31 with K_MAX=16 -> COMPUTE lasts 22 cycles. start_i during LOAD (macro off) -> no effect.
- With SYSTOLIC_TILE_CTRL_BACK2BACK_EN: start_i (k_len_i=2) during DRAIN -> done_o pulses on the last handshake, the next cycle is LOAD, and the following COMPUTE lasts 8 cycles; no IDLE cycle between tiles.
